// File: rtl/iterative_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_normalizer_if
//  Description : Operand/result handshake bundle for iterative_normalizer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iterative_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sig;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sig;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_underflow;
  logic        out_overflow;
  logic [4:0]  out_shifts;

  modport master (
    output in_valid, in_sig, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_sig, out_exp, out_sign,
           out_zero, out_underflow, out_overflow, out_shifts
  );

  modport slave (
    input  in_valid, in_sig, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_sig, out_exp, out_sign,
           out_zero, out_underflow, out_overflow, out_shifts
  );
endinterface
`default_nettype wire

// File: rtl/iterative_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_normalizer
//  Description : One-decision-per-cycle FP significand normalizer with
//                rounding right shift, exponent tracking and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_normalizer #(
  parameter int EXP_BIAS = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  iterative_normalizer_if.slave bus
);

  // The bias is only a reference point; reject values that are not a legal
  // normal biased exponent.
  if (EXP_BIAS < 1 || EXP_BIAS > 254) begin : g_bias_range
    $error("iterative_normalizer: EXP_BIAS out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state,   nxt_state;
  logic [31:0] r_sig,     nxt_sig;
  logic [7:0]  r_exp,     nxt_exp;
  logic        r_sign,    nxt_sign;
  logic [4:0]  r_shifts,  nxt_shifts;
  logic [23:0] r_out_sig, nxt_out_sig;
  logic [7:0]  r_out_exp, nxt_out_exp;
  logic        r_zero,    nxt_zero;
  logic        r_unf,     nxt_unf;
  logic        r_ovf,     nxt_ovf;

  logic [31:0] w_sig_half;
  logic [7:0]  w_exp_inc;

  // Right step rounds on the discarded bit; a carry back into bit 24 is
  // left for the following NORM cycle to catch.
  assign w_sig_half = {1'b0, r_sig[31:1]} + {31'd0, r_sig[0]};
  assign w_exp_inc  = r_exp + 8'd1;

  always_comb begin
    nxt_state   = r_state;
    nxt_sig     = r_sig;
    nxt_exp     = r_exp;
    nxt_sign    = r_sign;
    nxt_shifts  = r_shifts;
    nxt_out_sig = r_out_sig;
    nxt_out_exp = r_out_exp;
    nxt_zero    = r_zero;
    nxt_unf     = r_unf;
    nxt_ovf     = r_ovf;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          nxt_sig     = bus.in_sig;
          nxt_exp     = bus.in_exp;
          nxt_sign    = bus.in_sign;
          nxt_shifts  = 5'd0;
          nxt_out_sig = 24'd0;
          nxt_out_exp = 8'd0;
          nxt_zero    = 1'b0;
          nxt_unf     = 1'b0;
          nxt_ovf     = 1'b0;
          nxt_state   = NORM;
        end
      end

      NORM: begin
        if (r_sig == 32'd0) begin
          nxt_zero    = 1'b1;
          nxt_out_exp = 8'd0;
          nxt_out_sig = 24'd0;
          nxt_state   = DONE;
        end else if (|r_sig[31:24]) begin
          nxt_sig = w_sig_half;
          nxt_exp = w_exp_inc;
          if (w_exp_inc == 8'hFF) begin
            nxt_ovf     = 1'b1;
            nxt_out_sig = 24'd0;
            nxt_out_exp = 8'hFF;
            nxt_state   = DONE;
          end
        end else if (r_sig[23]) begin
          nxt_out_sig = r_sig[23:0];
          nxt_out_exp = r_exp;
          nxt_state   = DONE;
        end else if (r_exp > 8'd1) begin
          nxt_sig    = {r_sig[30:0], 1'b0};
          nxt_exp    = r_exp - 8'd1;
          nxt_shifts = r_shifts + 5'd1;
        end else begin
          nxt_unf     = 1'b1;
          nxt_out_exp = 8'd0;
          nxt_out_sig = r_sig[23:0];
          nxt_state   = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          nxt_state = IDLE;
        end
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sig     <= 32'd0;
      r_exp     <= 8'd0;
      r_sign    <= 1'b0;
      r_shifts  <= 5'd0;
      r_out_sig <= 24'd0;
      r_out_exp <= 8'd0;
      r_zero    <= 1'b0;
      r_unf     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= nxt_state;
      r_sig     <= nxt_sig;
      r_exp     <= nxt_exp;
      r_sign    <= nxt_sign;
      r_shifts  <= nxt_shifts;
      r_out_sig <= nxt_out_sig;
      r_out_exp <= nxt_out_exp;
      r_zero    <= nxt_zero;
      r_unf     <= nxt_unf;
      r_ovf     <= nxt_ovf;
    end
  end

  assign bus.in_ready      = (r_state == IDLE) && rst_n;
  assign bus.out_valid     = (r_state == DONE);
  assign bus.out_sig       = r_out_sig;
  assign bus.out_exp       = r_out_exp;
  assign bus.out_sign      = r_sign;
  assign bus.out_zero      = r_zero;
  assign bus.out_underflow = r_unf;
  assign bus.out_overflow  = r_ovf;
  assign bus.out_shifts    = r_shifts;

  a_flags_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0({r_zero, r_unf, r_ovf})
  );

  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rst_n)
      (r_state == DONE && !bus.out_ready) |=>
        (r_state == DONE && $stable(r_out_sig) && $stable(r_out_exp))
  );

endmodule
`default_nettype wire

// File: tb/tb_iterative_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iterative_normalizer
//  Description : Directed table, corner sequences and randomized operands
//                checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_normalizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iterative_normalizer_if nif ();

  iterative_normalizer #(.EXP_BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nif.slave)
  );

  typedef struct {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic [4:0]  sh;
    logic [2:0]  flags;  // {zero, underflow, overflow}
    int          lat;
  } res_t;

  typedef struct {
    logic [31:0] in_sig;
    logic [7:0]  in_exp;
    logic        in_sign;
    res_t        r;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: ceiling-halve until under 2^24, then the left distance to
  // bit 23 limited by how far the exponent may fall (down to 1).
  function automatic res_t model(input logic [31:0] s_in, input logic [7:0] e_in);
    res_t   r;
    longint s;
    int     e, dec, p, need, avail;
    r = '{sig: 24'd0, exp: 8'd0, sh: 5'd0, flags: 3'b000, lat: 0};
    s = longint'(s_in);
    e = int'(e_in);
    dec = 0;
    if (s == 0) begin
      r.flags = 3'b100;
      r.lat = 2;
      return r;
    end
    while (s >= 64'd16777216) begin
      s = (s + 1) / 2;
      e = (e + 1) % 256;
      dec++;
      if (e == 255) begin
        r.flags = 3'b001;
        r.exp = 8'hFF;
        r.lat = dec + 1;
        return r;
      end
    end
    p = 0;
    for (int i = 0; i < 24; i++) if (((s >> i) & 1) == 1) p = i;
    need  = 23 - p;
    avail = (e > 1) ? e - 1 : 0;
    if (need <= avail) begin
      r.sig = 24'(s << need);
      r.exp = 8'(e - need);
      r.sh  = 5'(need);
      dec  += need + 1;
    end else begin
      r.flags = 3'b010;
      r.sig = 24'(s << avail);
      r.exp = 8'd0;
      r.sh  = 5'(avail);
      dec  += avail + 1;
    end
    r.lat = dec + 1;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    nif.in_valid = 1'b0;
    nif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Call at a negedge; returns just after the accept edge.
  task automatic start_op(input logic [31:0] s, input logic [7:0] e, input logic sg);
    int n = 0;
    while (!nif.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!nif.in_ready) chk("start_timeout", 32'(nif.in_ready), 32'd1);
    nif.in_valid = 1'b1;
    nif.in_sig   = s;
    nif.in_exp   = e;
    nif.in_sign  = sg;
    @(posedge clk);
  endtask

  // Scribbles on the inputs while busy; those must all be ignored.
  task automatic wait_valid(output int lat, output bit ok);
    lat = 1;
    @(negedge clk);
    while (!nif.out_valid && lat < 40) begin
      nif.in_valid = 1'($urandom);
      nif.in_sig   = $urandom;
      nif.in_exp   = 8'($urandom);
      nif.in_sign  = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    ok = nif.out_valid;
    if (!ok) chk("valid_timeout", 32'(nif.out_valid), 32'd1);
  endtask

  task automatic finish_op();
    nif.out_ready = 1'b1;
    nif.in_valid  = 1'b0;
    @(negedge clk);
    nif.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic sg, input res_t r, input int lat);
    chk({tag, ".sig"},    32'(nif.out_sig), 32'(r.sig));
    chk({tag, ".exp"},    32'(nif.out_exp), 32'(r.exp));
    chk({tag, ".sign"},   32'(nif.out_sign), 32'(sg));
    chk({tag, ".flags"},  32'({nif.out_zero, nif.out_underflow, nif.out_overflow}), 32'(r.flags));
    chk({tag, ".shifts"}, 32'(nif.out_shifts), 32'(r.sh));
    chk({tag, ".lat"},    32'(lat), 32'(r.lat));
    chk({tag, ".busy"},   32'(nif.in_ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] s, input logic [7:0] e,
                        input logic sg, input res_t r);
    int lat;
    bit ok;
    start_op(s, e, sg);
    wait_valid(lat, ok);
    if (ok) begin
      check_result(tag, sg, r, lat);
      finish_op();
    end else begin
      do_reset();
    end
  endtask

  vec_t vecs[10];

  initial begin : main
    int lat;
    bit ok;
    logic [23:0] hold_sig;
    logic [7:0]  hold_exp;
    logic [4:0]  hold_sh;
    logic [2:0]  hold_fl;
    res_t r;
    logic [31:0] s;
    logic [7:0]  e;
    logic        sg;

    vecs[0] = '{32'h00800000, 8'd127, 1'b0, '{24'h800000, 8'd127, 5'd0,  3'b000, 2}};
    vecs[1] = '{32'h00000001, 8'd127, 1'b1, '{24'h800000, 8'd104, 5'd23, 3'b000, 25}};
    vecs[2] = '{32'h01000001, 8'd100, 1'b0, '{24'h800001, 8'd101, 5'd0,  3'b000, 3}};
    vecs[3] = '{32'h01000000, 8'd254, 1'b1, '{24'h000000, 8'd255, 5'd0,  3'b001, 2}};
    vecs[4] = '{32'h00000100, 8'd3,   1'b0, '{24'h000400, 8'd0,   5'd2,  3'b010, 4}};
    vecs[5] = '{32'h00000000, 8'd50,  1'b1, '{24'h000000, 8'd0,   5'd0,  3'b100, 2}};
    vecs[6] = '{32'hFFFFFFFF, 8'd10,  1'b0, '{24'h800000, 8'd19,  5'd0,  3'b000, 11}};
    vecs[7] = '{32'h01FFFFFF, 8'd20,  1'b1, '{24'h800000, 8'd22,  5'd0,  3'b000, 4}};
    vecs[8] = '{32'h00000003, 8'd1,   1'b0, '{24'h000003, 8'd0,   5'd0,  3'b010, 2}};
    vecs[9] = '{32'h00400000, 8'd2,   1'b1, '{24'h800000, 8'd1,   5'd1,  3'b000, 3}};

    rst_n = 1'b0;
    nif.in_valid = 1'b0;
    nif.out_ready = 1'b0;
    nif.in_sig = 32'd0;
    nif.in_exp = 8'd0;
    nif.in_sign = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 32'(nif.in_ready), 32'd0);
    chk("rst.out_valid", 32'(nif.out_valid), 32'd0);
    chk("rst.outs", 32'({nif.out_sig, nif.out_exp}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready_after", 32'(nif.in_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].in_sig, vecs[i].in_exp, vecs[i].in_sign, vecs[i].r);
    end

    // Backpressure: result must hold, inputs ignored, hand-off then IDLE.
    r = model(32'h00000100, 8'd3);
    start_op(32'h00000100, 8'd3, 1'b1);
    wait_valid(lat, ok);
    if (ok) begin
      check_result("bp", 1'b1, r, lat);
      hold_sig = nif.out_sig;
      hold_exp = nif.out_exp;
      hold_sh  = nif.out_shifts;
      hold_fl  = {nif.out_zero, nif.out_underflow, nif.out_overflow};
      for (int k = 0; k < 3; k++) begin
        nif.in_valid = 1'b1;
        nif.in_sig   = 32'h00800000;
        nif.in_exp   = 8'd9;
        @(negedge clk);
        chk("bp.valid", 32'(nif.out_valid), 32'd1);
        chk("bp.ready", 32'(nif.in_ready), 32'd0);
        chk("bp.hold", 32'({hold_sig, hold_exp}), 32'({nif.out_sig, nif.out_exp}));
        chk("bp.holdfl", 32'({hold_sh, hold_fl}),
            32'({nif.out_shifts, nif.out_zero, nif.out_underflow, nif.out_overflow}));
      end
      finish_op();
      chk("bp.ready_next", 32'(nif.in_ready), 32'd1);
      chk("bp.valid_drop", 32'(nif.out_valid), 32'd0);
    end else begin
      do_reset();
    end

    // Reset for one edge in the middle of a long normalization.
    start_op(32'h00000001, 8'd127, 1'b1);
    nif.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.ready_low", 32'(nif.in_ready), 32'd0);
    chk("mid.valid", 32'(nif.out_valid), 32'd0);
    chk("mid.shifts", 32'(nif.out_shifts), 32'd0);
    chk("mid.sign", 32'(nif.out_sign), 32'd0);
    chk("mid.outs", 32'({nif.out_sig, nif.out_exp}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid.idle", 32'(nif.in_ready), 32'd1);
    run_op("mid.new", 32'h00800000, 8'd127, 1'b0, model(32'h00800000, 8'd127));

    // Randomized operands over the full range of shift distances.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       s = $urandom;
        1:       s = $urandom >> $urandom_range(0, 31);
        2:       s = 32'd1 << $urandom_range(0, 31);
        default: s = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom & 32'h00FFFFFF) >> $urandom_range(0, 23);
      endcase
      e  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      sg = 1'($urandom);
      run_op($sformatf("rnd%0d", n), s, e, sg, model(s, e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/iterative_normalizer.md
ITERATIVE_NORMALIZER -- requirements
Module: iterative_normalizer

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, used only as the reset/idle reference value (no arithmetic effect).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  input operand valid.
REQ-005 SHALL have port in_ready  out  1  block can accept operand.
REQ-006 SHALL have port in_sig  in  32  unnormalized significand from the FP ALU; hidden-bit target is bit 23.
REQ-007 SHALL have port in_exp  in  8  biased exponent of in_sig.
REQ-008 SHALL have port in_sign  in  1  sign, passed through unchanged.
REQ-009 SHALL have port out_valid  out  1  result valid.
REQ-010 SHALL have port out_ready  in  1  consumer accepts result.
REQ-011 SHALL have port out_sig  out  24  normalized significand, hidden bit at bit 23.
REQ-012 SHALL have port out_exp  out  8  adjusted biased exponent.
REQ-013 SHALL have ports out_sign, out_zero, out_underflow, out_overflow  out  1 each.
REQ-014 SHALL have port out_shifts  out  5  count of left shifts applied.

Function
REQ-015 SHALL implement states IDLE, NORM, DONE; in_ready=1 only in IDLE with rst_n high.
REQ-016 IDLE: on in_valid&&in_ready, SHALL register in_sig/in_exp/in_sign, clear out_shifts, go NORM.
REQ-017 NORM, one decision per cycle, priority order:
  a) sig==0 -> out_zero=1, out_exp=0, out_sig=0, go DONE;
  b) any of sig[31:24] set -> sig=(sig>>1)+sig[0] (round on discarded bit), exp+1; if new exp==255 -> out_overflow=1, out_sig=0, out_exp=255, go DONE;
  c) sig[23] set -> out_sig=sig[23:0], go DONE;
  d) exp>1 -> sig=sig<<1, exp-1, out_shifts+1, stay NORM;
  e) exp<=1 -> out_underflow=1, out_exp=0, out_sig=sig[23:0] (denormal significand), go DONE.
REQ-018 Rounding carry from (b) SHALL be re-evaluated on the next NORM cycle, never in the same cycle.
REQ-019 Latency: already-normalized operand -> out_valid high 2 cycles after accept edge; each extra shift adds exactly 1 cycle; worst case (23 left shifts) 25 cycles.
REQ-020 DONE: out_valid=1; out_* SHALL hold stable while out_valid&&!out_ready; on out_ready go IDLE next edge.
REQ-021 No same-cycle handoff: in_ready=0 in DONE; minimum accept-to-accept spacing 3 cycles.
REQ-022 in_valid while not in IDLE SHALL be ignored; input ports sampled only at the accept edge.
REQ-023 out_sign SHALL equal captured in_sign in all cases, including zero.
REQ-024 Exactly one of out_zero/out_underflow/out_overflow or none SHALL be set per result.

Reset
REQ-025 rst_n low at any edge, any state (including mid-NORM or DONE), SHALL force IDLE, discard in-flight operand, zero all outputs and out_shifts, out_valid=0.
REQ-026 in_ready SHALL be 0 while rst_n low and 1 in first cycle after rst_n high.

Verification
REQ-027 in_sig=0x00800000, in_exp=127 -> out_sig=0x800000, out_exp=127, out_shifts=0, out_valid 2 cycles after accept.
REQ-028 in_sig=0x00000001, in_exp=127 -> out_sig=0x800000, out_exp=104, out_shifts=23, out_valid 25 cycles after accept.
REQ-029 in_sig=0x01000001, in_exp=100 -> out_sig=0x800001, out_exp=101, no flags; in_sig=0x01000000, in_exp=254 -> out_overflow=1, out_exp=255, out_sig=0.
REQ-030 in_sig=0x00000100, in_exp=3 -> out_underflow=1, out_exp=0, out_sig=0x000400, out_shifts=2; in_sig=0 -> out_zero=1, out_exp=0, 2 cycles.
REQ-031 Backpressure: out_ready low 3 cycles in DONE -> out_* unchanged, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 next cycle.
REQ-032 rst_n low for one edge during NORM of in_sig=0x00000001 -> outputs zero, IDLE next cycle; new operand 0x00800000 then completes in 2 cycles with correct result.
